// File: rtl/mii_tx_framer.sv
// Byte-wide MII transmit framer: wraps an AXI-stream payload with preamble/SFD,
// optional zero padding and CRC-32 FCS, then enforces the inter-frame gap.
module mii_tx_framer #(
    parameter logic [7:0] PREAMBLE         = 8'h55,
    parameter logic [7:0] SFD              = 8'hd5,
    parameter int         PREAMBLE_LENGTH  = 7,
    parameter bit         ENABLE_PAD       = 1'b1,
    parameter int         MIN_FRAME_LENGTH = 60,
    parameter bit         ENABLE_FCS       = 1'b1,
    parameter int         IFG_LENGTH       = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] saxis_tdata,
    input  logic       saxis_tvalid,
    output logic       saxis_tready,
    input  logic       saxis_tlast,
    output logic [7:0] maxis_tdata,
    output logic       maxis_tvalid,
    input  logic       maxis_tready,
    output logic       maxis_tlast
);

    localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LENGTH - 1);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_LENGTH);
    localparam logic [15:0] IFG_LAST = 16'(IFG_LENGTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DATA, ST_PAD, ST_FCS, ST_IFG
    } state_t;

    state_t      state_q;
    logic [7:0]  tdata_q;
    logic        tvalid_q, tlast_q;
    logic        crc_en_q;   // output register holds a payload/pad byte
    logic        last_in_q;  // upstream tlast already taken
    logic [15:0] cnt_q, cnt_inc, ifg_q;
    logic [3:0]  idx_q;
    logic [31:0] crc_q, crc_d, fcs_word;
    logic        out_hs, out_free, in_hs, launch;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign out_hs   = tvalid_q && maxis_tready;
    assign out_free = !tvalid_q || maxis_tready;
    assign in_hs    = saxis_tvalid && saxis_tready;
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    // The CRC absorbs a byte when it leaves, so the first FCS byte sees the final payload/pad byte.
    assign crc_d    = (out_hs && crc_en_q) ? crc_byte(crc_q, tdata_q) : crc_q;
    assign fcs_word = ~crc_d;
    assign launch   = saxis_tvalid &&
                      (state_q == ST_IDLE || (state_q == ST_IFG && ifg_q == IFG_LAST));

    assign maxis_tdata  = tdata_q;
    assign maxis_tvalid = tvalid_q;
    assign maxis_tlast  = tlast_q;

    always_comb begin
        saxis_tready = 1'b0;
        case (state_q)
            ST_SFD:  saxis_tready = maxis_tready;
            ST_DATA: saxis_tready = out_free && !last_in_q;
            default: saxis_tready = 1'b0;
        endcase
        if (reset) saxis_tready = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            crc_en_q  <= 1'b0;
            last_in_q <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            ifg_q     <= '0;
            crc_q     <= '1;
        end else if (launch) begin
            state_q   <= ST_PREAMBLE;
            tdata_q   <= PREAMBLE;
            tvalid_q  <= 1'b1;
            tlast_q   <= 1'b0;
            crc_en_q  <= 1'b0;
            last_in_q <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            crc_q     <= '1;
        end else if (tlast_q && out_hs) begin
            state_q  <= (IFG_LENGTH == 0) ? ST_IDLE : ST_IFG;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            crc_en_q <= 1'b0;
            ifg_q    <= '0;
            crc_q    <= '1;
        end else begin
            crc_q <= crc_d;
            case (state_q)
                ST_IDLE: crc_q <= '1;
                ST_PREAMBLE: if (out_hs) begin
                    idx_q <= idx_q + 4'd1;
                    if (idx_q == PRE_LAST) begin
                        tdata_q <= SFD;
                        state_q <= ST_SFD;
                    end
                end
                ST_SFD, ST_DATA: if (out_free) begin
                    state_q <= ST_DATA;
                    if (in_hs) begin
                        tdata_q  <= saxis_tdata;
                        tvalid_q <= 1'b1;
                        crc_en_q <= 1'b1;
                        cnt_q    <= cnt_inc;
                        if (saxis_tlast) begin
                            last_in_q <= 1'b1;
                            if (ENABLE_PAD && cnt_inc < MIN_LEN) begin
                                state_q <= ST_PAD;
                            end else if (ENABLE_FCS) begin
                                state_q <= ST_FCS;
                                idx_q   <= '0;
                            end else begin
                                tlast_q <= 1'b1;
                            end
                        end
                    end else begin
                        tvalid_q <= 1'b0;
                        crc_en_q <= 1'b0;
                    end
                end
                ST_PAD: if (out_free) begin
                    tdata_q  <= 8'h00;
                    tvalid_q <= 1'b1;
                    crc_en_q <= 1'b1;
                    cnt_q    <= cnt_inc;
                    if (cnt_inc == MIN_LEN) begin
                        if (ENABLE_FCS) begin
                            state_q <= ST_FCS;
                            idx_q   <= '0;
                        end else begin
                            tlast_q <= 1'b1;
                        end
                    end
                end
                ST_FCS: if (out_free) begin
                    tdata_q  <= fcs_word[{idx_q[1:0], 3'b000} +: 8];
                    tvalid_q <= 1'b1;
                    crc_en_q <= 1'b0;
                    idx_q    <= idx_q + 4'd1;
                    if (idx_q == 4'd3) tlast_q <= 1'b1;
                end
                ST_IFG: begin
                    crc_q <= '1;
                    ifg_q <= ifg_q + 16'd1;
                    if (ifg_q == IFG_LAST) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
